// File: rtl/serial_pkg.sv
// Shared types for the serial front-end: the serializer state encoding and the
// counter-width helper, also used by the downstream sequence detectors.
package serial_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // Bit-index counter width; never narrower than one bit.
   function automatic int cnt_width(input int width);
      if (width <= 2) begin
         return 1;
      end
      return $clog2(width);
   endfunction

endpackage

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: takes WIDTH-bit words over valid/ready and
// emits one bit per shift_en cycle, streaming back-to-back words gaplessly.
module piso_bit_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             shift_en,
   output logic             serial_out,
   output logic             bit_valid,
   output logic             word_done
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   ser_state_t       state_q;
   ser_state_t       state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic [WIDTH-1:0] shreg_adv;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             at_last;
   logic             accept;
   logic             data_bit;

   assign at_last  = (cnt_q == LAST);
   assign in_ready = (state_q == IDLE) || (at_last && shift_en);
   assign accept   = in_valid && in_ready;

   // The presented bit always sits at the outgoing end of the register.
   assign data_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
   assign shreg_adv = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};

   assign serial_out = (state_q == SHIFT) ? data_bit : IDLE_LEVEL;
   assign bit_valid  = (state_q == SHIFT) && shift_en;
   assign word_done  = bit_valid && at_last;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               shreg_d = in_data;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (shift_en) begin
               if (at_last) begin
                  // Reloading on the last bit is what keeps consecutive words bubble-free.
                  if (accept) begin
                     shreg_d = in_data;
                     cnt_d   = '0;
                  end else begin
                     state_d = IDLE;
                     shreg_d = '0;
                     cnt_d   = '0;
                  end
               end else begin
                  shreg_d = shreg_adv;
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Scoreboard bench for piso_bit_serializer: three instances (8-bit MSB-first,
// 8-bit LSB-first with idle level 1, 5-bit MSB-first) share one clock.
module tb_piso_bit_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst_v;
   logic [2:0] in_valid_v;
   logic [2:0] shift_en_v;
   logic [7:0] data_a;
   logic [7:0] data_b;
   logic [4:0] data_c;
   wire  [2:0] in_ready_v;
   wire  [2:0] serial_v;
   wire  [2:0] bit_valid_v;
   wire  [2:0] word_done_v;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;
   int accept_cycle;
   int first_accept;

   typedef struct {
      logic b;
      logic last;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
      .clk(clk), .rst(rst_v[0]), .in_data(data_a), .in_valid(in_valid_v[0]),
      .in_ready(in_ready_v[0]), .shift_en(shift_en_v[0]), .serial_out(serial_v[0]),
      .bit_valid(bit_valid_v[0]), .word_done(word_done_v[0])
   );

   piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
      .clk(clk), .rst(rst_v[1]), .in_data(data_b), .in_valid(in_valid_v[1]),
      .in_ready(in_ready_v[1]), .shift_en(shift_en_v[1]), .serial_out(serial_v[1]),
      .bit_valid(bit_valid_v[1]), .word_done(word_done_v[1])
   );

   piso_bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_c (
      .clk(clk), .rst(rst_v[2]), .in_data(data_c), .in_valid(in_valid_v[2]),
      .in_ready(in_ready_v[2]), .shift_en(shift_en_v[2]), .serial_out(serial_v[2]),
      .bit_valid(bit_valid_v[2]), .word_done(word_done_v[2])
   );

   always @(negedge clk) cycle++;

   task automatic compareBit(input string name, input int i, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s dut=%0d got=%b want=%b", name, i, got, want);
      end
   endtask

   task automatic compareInt(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // seq holds the hand-computed wire order, first transmitted bit at seq[n-1].
   task automatic pushExp(input int i, input logic [15:0] seq, input int n);
      exp_t e;
      for (int k = n - 1; k >= 0; k--) begin
         e.b    = seq[k];
         e.last = (k == 0);
         case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Offers a word at a negedge, holds it until accepted, returns at the next negedge.
   task automatic applyStimulus(input int i, input logic [7:0] word, input logic [15:0] seq,
                                input int n);
      bit done = 1'b0;
      case (i)
         0:       data_a = word;
         1:       data_b = word;
         default: data_c = word[4:0];
      endcase
      in_valid_v[i] = 1'b1;
      for (int t = 0; t < 40 && !done; t++) begin
         #1;
         if (in_ready_v[i] === 1'b1) begin
            @(posedge clk);
            accept_cycle = cycle;
            pushExp(i, seq, n);
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      checks++;
      if (!done) begin
         failures++;
         $display("[TB] FAIL handshake_timeout dut=%0d got=no_accept want=accept_within_40", i);
      end
      @(negedge clk);
      in_valid_v[i] = 1'b0;
   endtask

   task automatic checkOutput(input string name, input int i, input logic exp_serial,
                              input logic exp_bv, input logic exp_wd, input logic exp_ready);
      #1;
      compareBit({name, "_serial"}, i, serial_v[i], exp_serial);
      compareBit({name, "_bit_valid"}, i, bit_valid_v[i], exp_bv);
      compareBit({name, "_word_done"}, i, word_done_v[i], exp_wd);
      compareBit({name, "_in_ready"}, i, in_ready_v[i], exp_ready);
   endtask

   task automatic monitorPop(input int i);
      exp_t e;
      int   sz;
      case (i)
         0:       sz = q0.size();
         1:       sz = q1.size();
         default: sz = q2.size();
      endcase
      if (sz == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL unexpected_bit dut=%0d got=serial_%b want=no_bit", i, serial_v[i]);
      end else begin
         case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         compareBit("mon_serial", i, serial_v[i], e.b);
         compareBit("mon_word_done", i, word_done_v[i], e.last);
         compareBit("mon_in_ready", i, in_ready_v[i], e.last);
      end
   endtask

   // Monitor samples after the driver has settled each cycle's inputs.
   always @(negedge clk) begin
      #2;
      for (int i = 0; i < 3; i++) begin
         if (bit_valid_v[i] === 1'b1) begin
            monitorPop(i);
         end else if (rst_v[i] === 1'b0) begin
            compareBit("mon_no_done", i, word_done_v[i], 1'b0);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_v      = 3'b111;
      in_valid_v = 3'b000;
      shift_en_v = 3'b111;
      data_a     = 8'h00;
      data_b     = 8'h00;
      data_c     = 5'h00;
      waitCycles(2);
      rst_v = 3'b000;
      checkOutput("reset", 0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("reset", 1, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("reset", 2, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] single word 8'h93 MSB first");
      waitCycles(1);
      applyStimulus(0, 8'h93, 16'b10010011, 8);
      checkOutput("first_bit", 0, 1'b1, 1'b1, 1'b0, 1'b0);
      waitCycles(7);
      checkOutput("last_bit", 0, 1'b1, 1'b1, 1'b1, 1'b1);
      waitCycles(1);
      checkOutput("idle_after", 0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] back-to-back 8'hA5 then 8'h3C");
      waitCycles(1);
      applyStimulus(0, 8'hA5, 16'b10100101, 8);
      first_accept = accept_cycle;
      applyStimulus(0, 8'h3C, 16'b00111100, 8);
      compareInt("b2b_accept_gap", accept_cycle - first_accept, 8);
      waitCycles(10);
      checkOutput("b2b_idle", 0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] stall on bit index 3 of 8'hF0");
      waitCycles(1);
      applyStimulus(0, 8'hF0, 16'b11110000, 8);
      waitCycles(3);
      shift_en_v[0] = 1'b0;
      for (int s = 0; s < 3; s++) begin
         checkOutput("stall", 0, 1'b1, 1'b0, 1'b0, 1'b0);
         waitCycles(1);
      end
      shift_en_v[0] = 1'b1;
      waitCycles(4);
      checkOutput("stall_done", 0, 1'b0, 1'b1, 1'b1, 1'b1);
      waitCycles(1);
      checkOutput("stall_idle", 0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] LSB first, idle level 1");
      waitCycles(1);
      applyStimulus(1, 8'h01, 16'b10000000, 8);
      checkOutput("lsb_first", 1, 1'b1, 1'b1, 1'b0, 1'b0);
      waitCycles(8);
      checkOutput("lsb_idle", 1, 1'b1, 1'b0, 1'b0, 1'b1);
      waitCycles(1);
      applyStimulus(1, 8'hB2, 16'b01001101, 8);
      waitCycles(9);
      checkOutput("lsb_idle2", 1, 1'b1, 1'b0, 1'b0, 1'b1);

      $display("[TB] reset mid-word during 8'hFF");
      waitCycles(1);
      applyStimulus(0, 8'hFF, 16'b11111111, 8);
      waitCycles(4);
      rst_v[0]      = 1'b1;
      data_a        = 8'h55;
      in_valid_v[0] = 1'b1;
      @(posedge clk);
      q0.delete();
      @(negedge clk);
      checkOutput("rst_mid", 0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      rst_v[0]      = 1'b0;
      in_valid_v[0] = 1'b0;
      checkOutput("rst_no_accept", 0, 1'b0, 1'b0, 1'b0, 1'b1);
      waitCycles(3);
      checkOutput("rst_still_idle", 0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] WIDTH=5 words");
      waitCycles(1);
      applyStimulus(2, 8'b00010110, 16'b10110, 5);
      checkOutput("w5_first", 2, 1'b1, 1'b1, 1'b0, 1'b0);
      waitCycles(4);
      checkOutput("w5_last", 2, 1'b0, 1'b1, 1'b1, 1'b1);
      waitCycles(1);
      checkOutput("w5_idle", 2, 1'b0, 1'b0, 1'b0, 1'b1);
      waitCycles(1);
      applyStimulus(2, 8'b00010110, 16'b10110, 5);
      first_accept = accept_cycle;
      applyStimulus(2, 8'b00001001, 16'b01001, 5);
      compareInt("w5_accept_gap", accept_cycle - first_accept, 5);
      waitCycles(8);
      checkOutput("w5_idle2", 2, 1'b0, 1'b0, 1'b0, 1'b1);

      waitCycles(2);
      compareInt("q0_drained", q0.size(), 0);
      compareInt("q1_drained", q1.size(), 0);
      compareInt("q2_drained", q2.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
